// File: rtl/crc_check_pkg.sv
// Shared types and helpers for the CRC result checker.
// Holds the checker FSM encoding and the signature rotate helper.
package crc_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    PASS,
    FAIL
  } chk_state_t;

  // Widest signature the rotate helper supports.
  localparam int ROT_MAX_W = 64;

  // Rotate left by one inside the low w bits of v.
  // Bits at or above w must be zero on entry.
  function automatic logic [ROT_MAX_W-1:0] rotl1(
    input logic [ROT_MAX_W-1:0] v,
    input int                   w
  );
    logic [ROT_MAX_W-1:0] mask;
    logic [ROT_MAX_W-1:0] wrap;
    if (w >= ROT_MAX_W) begin
      mask = '1;
    end else begin
      mask = (ROT_MAX_W'(1) << w) - ROT_MAX_W'(1);
    end
    wrap = v >> (w - 1);
    return ((v << 1) | wrap) & mask;
  endfunction

endpackage

// File: rtl/crc_result_checker_sig.sv
// Running signature register for the CRC result checker.
// Folds each accepted CRC as sig = rotl1(sig) ^ din.
module crc_sig_accum
  import crc_check_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  // Width-fixed wrapper around the package rotate.
  function automatic logic [W-1:0] rot(
    input logic [W-1:0] v
  );
    logic [ROT_MAX_W-1:0] r;
    r = rotl1(ROT_MAX_W'(v), W);
    return r[W-1:0];
  endfunction

  // Next signature: fold din when enabled.
  always_comb begin
    sig_d = sig_q;
    if (en) begin
      sig_d = rot(sig_q) ^ din;
    end
  end

  // Signature register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/crc_result_checker.sv
// On-board self-check stage behind crc_gen.
// Counts packets and results, signs results, and flags pass or fail.
module crc_result_checker
  import crc_check_pkg::*;
#(
  parameter int                   CRC_WIDTH      = 32,
  parameter logic [7:0]           PKT_LIMIT      = 8'd100,
  parameter logic [CRC_WIDTH-1:0] EXP_SIG        = '0,
  parameter int                   CNT_W          = 16,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_sent,
  input  logic                 gen_done,
  input  logic [CRC_WIDTH-1:0] crc_out,
  input  logic                 crc_out_vld,
  output logic [CNT_W-1:0]     sent_cnt,
  output logic [CNT_W-1:0]     res_cnt,
  output logic [CRC_WIDTH-1:0] signature,
  output logic                 check_done,
  output logic                 pass,
  output logic                 fail,
  output logic                 err_extra,
  output logic                 err_timeout,
  output logic                 err_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(PKT_LIMIT);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);

  chk_state_t state_q;
  chk_state_t state_d;

  logic [CNT_W-1:0] sent_q;
  logic [CNT_W-1:0] sent_d;
  logic [CNT_W-1:0] res_q;
  logic [CNT_W-1:0] res_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;

  logic err_extra_q;
  logic err_extra_d;
  logic err_timeout_q;
  logic err_timeout_d;
  logic err_count_q;
  logic err_count_d;

  logic             sat_hit;
  logic [CNT_W:0]   outstanding;
  logic             is_extra;
  logic             drained;
  logic             pass_ok;
  logic             sig_en;
  logic             fsm_extra;
  logic             fsm_timeout;
  logic             fsm_count;
  logic [CRC_WIDTH-1:0] sig;

  // Nothing is folded while idle; an early result is only an error.
  assign sig_en = crc_out_vld && (state_q != IDLE);

  crc_sig_accum #(
    .W(CRC_WIDTH)
  ) u_sig (
    .clk (clk),
    .rst (rst),
    .en  (sig_en),
    .din (crc_out),
    .sig (sig)
  );

  // A same-cycle send counts as outstanding for this result.
  assign outstanding =
    {1'b0, sent_q} + {{CNT_W{1'b0}}, pkt_sent};
  assign is_extra =
    crc_out_vld && ({1'b0, res_q} >= outstanding);

  assign drained =
    (res_q == sent_q) && !crc_out_vld && !pkt_sent;

  assign pass_ok =
    (res_q == LIMIT) && (sig == EXP_SIG) &&
    !err_extra_q && !err_count_q;

  // Saturating packet and result counters.
  always_comb begin
    sent_d  = sent_q;
    res_d   = res_q;
    sat_hit = 1'b0;
    if (pkt_sent && (sent_q != CNT_MAX)) begin
      sent_d = sent_q + 1'b1;
      if (sent_d == CNT_MAX) begin
        sat_hit = 1'b1;
      end
    end
    if (crc_out_vld && (res_q != CNT_MAX)) begin
      res_d = res_q + 1'b1;
      if (res_d == CNT_MAX) begin
        sat_hit = 1'b1;
      end
    end
  end

  // Checker state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, drain timeout and FSM-raised errors.
  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    fsm_extra   = 1'b0;
    fsm_timeout = 1'b0;
    fsm_count   = 1'b0;
    unique case (state_q)
      IDLE: begin
        fsm_extra = crc_out_vld;
        if (gen_done) begin
          state_d = DRAIN;
        end else if (pkt_sent || crc_out_vld) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (gen_done) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        tmo_d = crc_out_vld ? '0 : tmo_q + 1'b1;
        if (drained) begin
          state_d   = pass_ok ? PASS : FAIL;
          fsm_count = (res_q != LIMIT);
        end else if (tmo_q == TMO_LAST) begin
          state_d     = FAIL;
          fsm_timeout = 1'b1;
        end
      end
      PASS: begin
        if (pkt_sent || crc_out_vld) begin
          state_d   = FAIL;
          fsm_extra = 1'b1;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky error flags accumulate until reset.
  always_comb begin
    err_extra_d   = err_extra_q | is_extra | fsm_extra;
    err_timeout_d = err_timeout_q | fsm_timeout;
    err_count_d   = err_count_q | sat_hit | fsm_count;
  end

  // Counter, timeout and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q        <= '0;
      res_q         <= '0;
      tmo_q         <= '0;
      err_extra_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= 1'b0;
    end else begin
      sent_q        <= sent_d;
      res_q         <= res_d;
      tmo_q         <= tmo_d;
      err_extra_q   <= err_extra_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  // Verdict outputs decoded from the registered state.
  always_comb begin
    check_done = 1'b0;
    pass       = 1'b0;
    fail       = 1'b0;
    unique case (state_q)
      PASS: begin
        check_done = 1'b1;
        pass       = 1'b1;
      end
      FAIL: begin
        check_done = 1'b1;
        fail       = 1'b1;
      end
      default: begin
        check_done = 1'b0;
      end
    endcase
  end

  assign sent_cnt    = sent_q;
  assign res_cnt     = res_q;
  assign signature   = sig;
  assign err_extra   = err_extra_q;
  assign err_timeout = err_timeout_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_crc_result_checker.sv
// Scoreboard bench for crc_result_checker.
// Directed traffic with hand-computed signatures and verdicts.
module tb_crc_result_checker;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pkt_sent = 1'b0;
  logic          gen_done = 1'b0;
  logic [W-1:0]  crc_out = '0;
  logic          crc_out_vld = 1'b0;
  logic [15:0]   sent_cnt;
  logic [15:0]   res_cnt;
  logic [W-1:0]  signature;
  logic          check_done;
  logic          pass;
  logic          fail;
  logic          err_extra;
  logic          err_timeout;
  logic          err_count;

  always #5 clk = ~clk;

  crc_result_checker #(
    .CRC_WIDTH      (W),
    .PKT_LIMIT      (8'd3),
    .EXP_SIG        (8'h04),
    .CNT_W          (16),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pkt_sent    (pkt_sent),
    .gen_done    (gen_done),
    .crc_out     (crc_out),
    .crc_out_vld (crc_out_vld),
    .sent_cnt    (sent_cnt),
    .res_cnt     (res_cnt),
    .signature   (signature),
    .check_done  (check_done),
    .pass        (pass),
    .fail        (fail),
    .err_extra   (err_extra),
    .err_timeout (err_timeout),
    .err_count   (err_count)
  );

  typedef struct {
    bit          full;
    logic        pass;
    logic        fail;
    logic [15:0] res;
    logic [15:0] sent;
    logic        ex;
    logic        tmo;
    logic        cnt;
    logic [W-1:0] sig;
    string       name;
  } out_t;

  typedef struct {
    bit           chk;
    logic [W-1:0] v;
  } sig_t;

  out_t oq[$];
  sig_t sq[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  logic       vld_seen = 1'b0;
  logic [1:0] pf_prev = 2'b00;

  always @(posedge clk) vld_seen <= crc_out_vld && !rst;

  always @(negedge clk) begin
    sig_t se;
    out_t oe;
    if (vld_seen) begin
      if (sq.size() == 0) begin
        chk("sig_unexpected", 64'(1), 64'(0));
      end else begin
        se = sq.pop_front();
        if (se.chk) chk("signature", 64'(signature), 64'(se.v));
      end
    end
    if ({pass, fail} != pf_prev && {pass, fail} != 2'b00) begin
      if (oq.size() == 0) begin
        chk("outcome_unexpected", 64'({pass, fail}), 64'(0));
      end else begin
        oe = oq.pop_front();
        chk({oe.name, "_pass"}, 64'(pass), 64'(oe.pass));
        chk({oe.name, "_fail"}, 64'(fail), 64'(oe.fail));
        chk({oe.name, "_err_extra"}, 64'(err_extra), 64'(oe.ex));
        if (oe.full) begin
          chk({oe.name, "_res_cnt"}, 64'(res_cnt), 64'(oe.res));
          chk({oe.name, "_sent_cnt"}, 64'(sent_cnt), 64'(oe.sent));
          chk({oe.name, "_err_timeout"}, 64'(err_timeout), 64'(oe.tmo));
          chk({oe.name, "_err_count"}, 64'(err_count), 64'(oe.cnt));
          chk({oe.name, "_sig"}, 64'(signature), 64'(oe.sig));
        end
      end
    end
    pf_prev = {pass, fail};
  end

  task automatic step(
    input logic         p,
    input logic         v,
    input logic [W-1:0] d
  );
    pkt_sent    = p;
    crc_out_vld = v;
    crc_out     = d;
    @(posedge clk);
    #1;
    pkt_sent    = 1'b0;
    crc_out_vld = 1'b0;
    crc_out     = '0;
  endtask

  task automatic do_reset(input string nm);
    rst      = 1'b1;
    gen_done = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    chk({nm, "_cnts"}, 64'({sent_cnt, res_cnt, signature}), 64'(0));
    chk({nm, "_flags"},
        64'({check_done, pass, fail, err_extra, err_timeout, err_count}),
        64'(0));
  endtask

  // Three sends; results 01, 02, last two cycles after each send.
  task automatic run3(
    input logic [W-1:0] last,
    input logic [W-1:0] last_sig,
    input bit           sc
  );
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    sq.push_back('{sc, 8'h01});
    step(1'b1, 1'b1, 8'h01);
    gen_done = 1'b1;
    sq.push_back('{sc, 8'h00});
    step(1'b0, 1'b1, 8'h02);
    sq.push_back('{sc, last_sig});
    step(1'b0, 1'b1, last);
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!check_done && n < lim) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
  endtask

  initial begin
    int n;
    @(posedge clk);
    #1;
    do_reset("reset0");

    // Clean run: signature 01, 00, 04 matches the golden value.
    oq.push_back('{1'b1, 1'b1, 1'b0, 16'd3, 16'd3,
                   1'b0, 1'b0, 1'b0, 8'h04, "clean"});
    run3(8'h04, 8'h04, 1'b1);
    chk("clean_pre_exit", 64'(check_done), 64'(0));
    step(1'b0, 1'b0, 8'h00);
    chk("clean_exit_latency", 64'(pass), 64'(1));

    // Wrong last result: signature 05, fail with no flag.
    do_reset("reset1");
    oq.push_back('{1'b1, 1'b0, 1'b1, 16'd3, 16'd3,
                   1'b0, 1'b0, 1'b0, 8'h05, "badsig"});
    run3(8'h05, 8'h05, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("badsig_fail", 64'(fail), 64'(1));

    // Missing result: drain times out 1024 cycles later.
    do_reset("reset2");
    oq.push_back('{1'b1, 1'b0, 1'b1, 16'd2, 16'd3,
                   1'b0, 1'b1, 1'b0, 8'h00, "timeout"});
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    sq.push_back('{1'b1, 8'h01});
    step(1'b1, 1'b1, 8'h01);
    gen_done = 1'b1;
    sq.push_back('{1'b1, 8'h00});
    step(1'b0, 1'b1, 8'h02);
    wait_done(1200, n);
    chk("timeout_latency", 64'(n), 64'(1024));

    // Result while idle: extra flagged, run ends in fail.
    do_reset("reset3");
    oq.push_back('{1'b0, 1'b0, 1'b1, 16'd0, 16'd0,
                   1'b1, 1'b0, 1'b0, 8'h00, "idle_extra"});
    sq.push_back('{1'b0, 8'h00});
    step(1'b0, 1'b1, 8'hAA);
    chk("idle_extra_flag", 64'(err_extra), 64'(1));
    run3(8'h04, 8'h04, 1'b0);
    wait_done(1200, n);
    chk("idle_extra_done", 64'(check_done), 64'(1));

    // Result after pass: 04 rotl -> 08, ^10 -> 18, verdict flips.
    do_reset("reset4");
    oq.push_back('{1'b1, 1'b1, 1'b0, 16'd3, 16'd3,
                   1'b0, 1'b0, 1'b0, 8'h04, "prepass"});
    run3(8'h04, 8'h04, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    oq.push_back('{1'b1, 1'b0, 1'b1, 16'd4, 16'd3,
                   1'b1, 1'b0, 1'b0, 8'h18, "postpass"});
    sq.push_back('{1'b1, 8'h18});
    step(1'b0, 1'b1, 8'h10);
    chk("postpass_drop", 64'(pass), 64'(0));

    // Reset in drain, then a clean repeat passes.
    do_reset("reset5");
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    sq.push_back('{1'b1, 8'h01});
    step(1'b1, 1'b1, 8'h01);
    gen_done = 1'b1;
    sq.push_back('{1'b1, 8'h00});
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b0, 8'h00);
    do_reset("middrain");
    oq.push_back('{1'b1, 1'b1, 1'b0, 16'd3, 16'd3,
                   1'b0, 1'b0, 1'b0, 8'h04, "repeat"});
    run3(8'h04, 8'h04, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("repeat_pass", 64'(pass), 64'(1));

    @(negedge clk);
    #1;
    chk("outcomes_drained", 64'(oq.size()), 64'(0));
    chk("sigs_drained", 64'(sq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
